// File: rtl/serial_alu_defs.sv
// Shared definitions for the bit-serial ALU units: FSM encoding and counter sizing.
package serial_alu_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 64;

    // A 1-bit counter is the minimum, so WIDTH=2 still gets a real register.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/one_bit_full_subtractor.sv
// Combinational one-bit full subtractor: d = a - b - b_in, with borrow out.
module one_bit_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LEGv8 SUB/SUBS unit, LSB first, one bit per clock, with NZCV flags.
// Define SERIAL_SUB_ADD_MODE_EN to add the op_add input and an add mode on the same datapath.
module serial_subtractor
    import serial_alu_defs::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             op_add,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_v_q, flag_v_d;

    logic add_mode;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic add_q, add_d;
    assign add_mode = add_q;
`else
    assign add_mode = 1'b0;
`endif

    logic             bit_a;
    logic             sub_d;
    logic             sub_bout;
    logic             res_bit;
    logic [WIDTH-1:0] diff_shift;

    // Adding reuses the subtractor: bout(~a, b, c) is the full-adder carry and
    // d(~a, b, c) is the inverted sum, so the borrow FF doubles as the carry FF.
    assign bit_a = shift_a_q[0] ^ add_mode;

    one_bit_full_subtractor u_fs (
        .a     (bit_a),
        .b     (shift_b_q[0]),
        .b_in  (borrow_q),
        .d     (sub_d),
        .b_out (sub_bout)
    );

    assign res_bit    = sub_d ^ add_mode;
    assign diff_shift = {res_bit, diff_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        diff_d    = diff_q;
        cnt_d     = cnt_q;
        borrow_d  = borrow_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        flag_n_d  = flag_n_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        flag_v_d  = flag_v_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
        add_d     = add_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_a_d = a;
                    shift_b_d = b;
                    a_msb_d   = a[WIDTH-1];
                    b_msb_d   = b[WIDTH-1];
                    borrow_d  = 1'b0;
                    cnt_d     = '0;
                    diff_d    = '0;
                    flag_n_d  = 1'b0;
                    flag_z_d  = 1'b0;
                    flag_c_d  = 1'b0;
                    flag_v_d  = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                    add_d     = op_add;
`endif
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                diff_d    = diff_shift;
                borrow_d  = sub_bout;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    flag_n_d = res_bit;
                    flag_z_d = ~|diff_shift;
                    if (add_mode) begin
                        flag_c_d = sub_bout;
                        flag_v_d = ~(a_msb_q ^ b_msb_q) & (a_msb_q ^ res_bit);
                    end else begin
                        flag_c_d = ~sub_bout;
                        flag_v_d = (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_bit);
                    end
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            borrow_q  <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_v_q  <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            add_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            diff_q    <= diff_d;
            cnt_q     <= cnt_d;
            borrow_q  <= borrow_d;
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            flag_n_q  <= flag_n_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            flag_v_q  <= flag_v_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
            add_q     <= add_d;
`endif
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign diff   = diff_q;
    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
    assign flag_v = flag_v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op_add;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         flag_n;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    serial_subtractor #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .op_add (op_add),
`endif
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .flag_n (flag_n),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_v (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result packed as {diff, N, Z, C, V}, from plain wide arithmetic.
    function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic add);
        logic [W:0]   u;
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        if (add) begin
            u = {1'b0, x} + {1'b0, y};
            s = {x[W-1], x} + {y[W-1], y};
            c = u[W];
        end else begin
            u = {1'b0, x} - {1'b0, y};
            s = {x[W-1], x} - {y[W-1], y};
            c = (x >= y);
        end
        r = u[W-1:0];
        return {r, r[W-1], (r == '0), c, s[W] ^ s[W-1]};
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Runs one job; ign > 0 pulses start again that many cycles after acceptance.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tadd,
                          input int ign, output logic [W+3:0] got, output int lat,
                          output int ndone);
        bit seen;
        @(negedge clk);
        a = ta;
        b = tb;
        op_add = tadd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = rnd64();
        b = rnd64();
        op_add = 1'b0;
        lat = 0;
        ndone = 0;
        seen = 0;
        got = '0;
        for (int i = 1; i <= W + 8; i++) begin
            start = (i == ign);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (!seen) begin
                    lat = i;
                    got = {diff, flag_n, flag_z, flag_c, flag_v};
                end
                seen = 1;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, diff, flag_n, flag_z, flag_c, flag_v} !== '0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%h nzcv=%b%b%b%b, want all 0",
                     busy, done, diff, flag_n, flag_z, flag_c, flag_v);
        end else passes++;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midrun();
        logic [W+3:0] got;
        logic [W+3:0] exp;
        int lat;
        int nd;
        int stray;
        @(negedge clk);
        a = 100;
        b = 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({busy, done, diff} !== '0) begin
            fails++;
            $display("FAIL midrun_reset: got busy=%b done=%b diff=%h, want 0 0 0", busy, done, diff);
        end else passes++;
        stray = 0;
        repeat (W + 10) begin
            @(posedge clk);
            #1;
            if (done) stray++;
        end
        checks++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL midrun_no_done: got %0d done pulses, want 0", stray);
        end else passes++;
        run_op(100, 1, 1'b0, 0, got, lat, nd);
        exp = model(100, 1, 1'b0);
        checks++;
        if (got !== exp || lat != W || nd != 1) begin
            fails++;
            $display("FAIL midrun_restart: got %h lat=%0d dones=%0d, want %h lat=%0d dones=1",
                     got, lat, nd, exp, W);
        end else passes++;
    endtask

    task automatic test_basic();
        logic [W+3:0] got;
        logic [W+3:0] exp;
        int lat;
        int nd;
        run_op(100, 58, 1'b0, 0, got, lat, nd);
        exp = {64'd42, 4'b0010};
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL basic_result: got %h, want %h", got, exp);
        end else passes++;
        checks++;
        if (lat != W || nd != 1) begin
            fails++;
            $display("FAIL basic_latency: got lat=%0d dones=%0d, want lat=%0d dones=1", lat, nd, W);
        end else passes++;
        checks++;
        if ({diff, flag_n, flag_z, flag_c, flag_v} !== exp || done !== 1'b0) begin
            fails++;
            $display("FAIL basic_hold: got %h done=%b, want %h done=0",
                     {diff, flag_n, flag_z, flag_c, flag_v}, done, exp);
        end else passes++;
    endtask

    task automatic test_negative();
        logic [W+3:0] got;
        int lat;
        int nd;
        run_op(0, 1, 1'b0, 0, got, lat, nd);
        checks++;
        if (got !== {64'hFFFF_FFFF_FFFF_FFFF, 4'b1000} || lat != W) begin
            fails++;
            $display("FAIL negative: got %h lat=%0d, want %h lat=%0d", got, lat,
                     {64'hFFFF_FFFF_FFFF_FFFF, 4'b1000}, W);
        end else passes++;
    endtask

    task automatic test_overflow();
        logic [W+3:0] got;
        int lat;
        int nd;
        run_op(64'h8000_0000_0000_0000, 1, 1'b0, 0, got, lat, nd);
        checks++;
        if (got !== {64'h7FFF_FFFF_FFFF_FFFF, 4'b0011} || lat != W) begin
            fails++;
            $display("FAIL overflow: got %h lat=%0d, want %h lat=%0d", got, lat,
                     {64'h7FFF_FFFF_FFFF_FFFF, 4'b0011}, W);
        end else passes++;
    endtask

    task automatic test_equal_ignored_start();
        logic [W+3:0] got;
        int lat;
        int nd;
        run_op(64'h1234, 64'h1234, 1'b0, 20, got, lat, nd);
        checks++;
        if (got !== {64'd0, 4'b0110}) begin
            fails++;
            $display("FAIL equal_result: got %h, want %h", got, {64'd0, 4'b0110});
        end else passes++;
        checks++;
        if (nd != 1 || lat != W) begin
            fails++;
            $display("FAIL ignored_start: got dones=%0d lat=%0d, want dones=1 lat=%0d", nd, lat, W);
        end else passes++;
    endtask

    task automatic test_random();
        logic [W+3:0] got;
        logic [W+3:0] exp;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int lat;
        int nd;
        for (int i = 0; i < 16; i++) begin
            x = rnd64();
            y = rnd64();
            case (i % 4)
                1: y = '0;
                2: y = x;
                3: y = x + W'($urandom_range(1, 3));
                default: ;
            endcase
            run_op(x, y, 1'b0, 0, got, lat, nd);
            exp = model(x, y, 1'b0);
            checks++;
            if (got !== exp || lat != W || nd != 1) begin
                fails++;
                $display("FAIL random_sub[%0d]: a=%h b=%h got %h lat=%0d dones=%0d, want %h lat=%0d",
                         i, x, y, got, lat, nd, exp, W);
            end else passes++;
        end
    endtask

`ifdef SERIAL_SUB_ADD_MODE_EN
    task automatic test_add();
        logic [W+3:0] got;
        logic [W+3:0] exp;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int lat;
        int nd;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1, 0, got, lat, nd);
        checks++;
        if (got !== {64'd0, 4'b0110} || lat != W) begin
            fails++;
            $display("FAIL add_wrap: got %h lat=%0d, want %h lat=%0d", got, lat,
                     {64'd0, 4'b0110}, W);
        end else passes++;
        for (int i = 0; i < 8; i++) begin
            x = rnd64();
            y = rnd64();
            run_op(x, y, 1'b1, 0, got, lat, nd);
            exp = model(x, y, 1'b1);
            checks++;
            if (got !== exp || lat != W) begin
                fails++;
                $display("FAIL random_add[%0d]: a=%h b=%h got %h lat=%0d, want %h", i, x, y, got,
                         lat, exp);
            end else passes++;
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        op_add = 1'b0;
        test_reset();
        test_reset_midrun();
        test_basic();
        test_negative();
        test_overflow();
        test_equal_ignored_start();
        test_random();
`ifdef SERIAL_SUB_ADD_MODE_EN
        test_add();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial LEGv8 subtract unit (SUB/SUBS), the inverse direction of the combinational adder path.
- Computes a - b LSB-first, one bit per clock, through a single borrow flip-flop.
- Sits beside the ALU as a low-area multi-cycle execute unit with a start/done handshake.
- Produces the difference and the LEGv8 NZCV flags.

Parameters:
- WIDTH, 64, operand and result width in bits (legal range 2..64).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH; held until the next accepted start.
- flag_n  output  1  diff[WIDTH-1].
- flag_z  output  1  diff == 0.
- flag_c  output  1  LEGv8 carry = NOT final borrow (1 when a >= b unsigned).
- flag_v  output  1  signed overflow.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, diff=0, all flags=0; borrow FF=0; bit counter=0. Reset has priority over every other event.
- Reset mid-operation aborts the job. No done is emitted.
- States:
  - IDLE: start=1 captures a→shift_a, b→shift_b, clears borrow and counter, clears diff, goes to SHIFT. start=0 stays in IDLE.
  - SHIFT, each cycle:
    - d = shift_a[0] ^ shift_b[0] ^ borrow.
    - borrow_next = (~shift_a[0] & shift_b[0]) | (~(shift_a[0] ^ shift_b[0]) & borrow).
    - shift_a and shift_b shift right by 1; d enters diff at the MSB and diff shifts right.
    - counter increments.
    - When counter == WIDTH-1, that cycle's bit completes; go to DONE.
  - DONE: done=1 for exactly this one cycle, with diff and flags valid. Go to IDLE unconditionally.
- Latency: start accepted at edge T; done high during cycle T+WIDTH+1. For WIDTH=64, throughput is one result per 66 cycles.
- Flags: registered on the SHIFT→DONE transition.
  - flag_c = ~final borrow.
  - flag_v = (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the captured operand MSBs.
  - flag_z uses the complete diff.
- diff and flags are held after done until the next accepted start.
- start while busy or in DONE is ignored. It is not queued; the requester retries in IDLE.
- Operand inputs may change freely after capture.
- Boundaries:
  - a == b → diff=0, Z=1, C=1.
  - a=0, b=1 → diff all-ones, N=1, C=0.
  - b=0 → diff=a, C=1, V=0.

Optional Feature:
- Macro SERIAL_SUB_ADD_MODE_EN.
- Defined: adds input port op_add (1 bit), captured with the operands.
  - op_add=1 runs the same datapath as an adder with a carry chain; the carry FF initialises to 0.
  - flag_c = final carry-out.
  - flag_v = ~(a_msb ^ b_msb) & (a_msb ^ diff_msb).
- Undefined: op_add does not exist; subtract only.
- Latency is identical in both builds.

Decomposition:
- Shared package/include serial_alu_defs:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - counter width constant CNT_W = clog2(WIDTH).
- Sub-module one_bit_full_subtractor: inputs a, b, b_in; outputs d, b_out; purely combinational.
  - Instantiated once. The borrow register lives in the parent.

Test Plan:
- Reset mid-run: start with a=100, b=1; assert reset at cycle 10 → busy=0 next cycle, diff=0, no done pulse; a fresh start then completes normally.
- Basic: a=100, b=58 → done at T+65, diff=42, N=0, Z=0, C=1, V=0.
- Negative result: a=0, b=1 → diff=64'hFFFF_FFFF_FFFF_FFFF, N=1, Z=0, C=0, V=0.
- Signed overflow: a=64'h8000_0000_0000_0000, b=1 → diff=64'h7FFF_FFFF_FFFF_FFFF, N=0, C=1, V=1.
- Equal operands plus ignored start: a=b=64'h1234; pulse start again at cycle 20 → exactly one done, diff=0, Z=1, C=1.
- Optional build with op_add=1: a=64'hFFFF_FFFF_FFFF_FFFF, b=1 → diff=0, Z=1, C=1, V=0.
